nx_fifo_thresh: RTL and testbench

NX_FIFO_THRESH -- requirements
Module: nx_fifo_thresh

---
 rtl/nx_fifo_thresh.sv | 155 +++++++++++++++
 tb/tb_nx_fifo_thresh.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nx_fifo_thresh.sv
// nx_fifo_thresh: single-clock show-ahead FIFO with occupancy/vacancy
// counters, programmable almost-full / almost-empty thresholds, registered
// overflow/underflow pulses and an optional peak-occupancy tracker.
//
// Optional feature macro: NX_FIFO_THRESH_HWM_EN
//   defined   -> high_water tracks peak used_slots since reset/clear
//   undefined -> high_water is tied to zero and no register is built
module nx_fifo_thresh #(
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 1,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int DATA_RESET = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wen,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         ren,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   used_slots,
    output logic [$clog2(DEPTH+1)-1:0]   free_slots,
    output logic                         overflow,
    output logic                         underflow,
    output logic [$clog2(DEPTH+1)-1:0]   high_water
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    used;

    logic wr_ok;
    logic rd_ok;
    logic wr_rej;
    logic rd_rej;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == LAST_C) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Flags come straight off the registered count.
    assign empty        = (used == '0);
    assign full         = (used == DEPTH_C);
    assign almost_full  = (used >= AF_C);
    assign almost_empty = (used <= AE_C);
    assign used_slots   = used;
    assign free_slots   = DEPTH_C - used;

    // A write into a full FIFO is dropped even if a read frees a slot in the
    // same cycle; a read from an empty FIFO never sees the same-cycle write.
    assign wr_ok  = wen & ~full;
    assign rd_ok  = ren & ~empty;
    assign wr_rej = wen & full & ~clear;
    assign rd_rej = ren & empty & ~clear;

    // Show-ahead head entry; sourced only from storage, never from wdata.
    assign rdata = empty ? '0 : mem[rptr];

    // Pointers and occupancy count; clear overrides any request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            used <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            used <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= next_ptr(wptr);
            end
            if (rd_ok) begin
                rptr <= next_ptr(rptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   used <= used + CW'(1);
                2'b01:   used <= used - CW'(1);
                default: used <= used;
            endcase
        end
    end

    // One-cycle error pulses for rejected requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_rej;
            underflow <= rd_rej;
        end
    end

    // Storage: optionally zeroed by reset; clear leaves contents untouched.
    generate
        if (DATA_RESET != 0) begin : g_mem_rst
            // Storage write with reset-to-zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else if (wr_ok && !clear) begin
                    mem[wptr] <= wdata;
                end
            end
        end else begin : g_mem_norst
            // Storage write without reset; rst still blocks in-flight writes.
            always_ff @(posedge clk) begin
                if (!rst && wr_ok && !clear) begin
                    mem[wptr] <= wdata;
                end
            end
        end
    endgenerate

`ifdef NX_FIFO_THRESH_HWM_EN
    logic [CW-1:0] hwm;

    // Peak occupancy, sampled from the registered count each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm <= '0;
        end else if (clear) begin
            hwm <= '0;
        end else if (used > hwm) begin
            hwm <= used;
        end
    end

    assign high_water = hwm;
`else
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_thresh.sv
// Self-checking bench for nx_fifo_thresh (DEPTH=5, WIDTH=8, AF=4, AE=1).
// Expected high_water follows whether NX_FIFO_THRESH_HWM_EN is defined.
module tb_nx_fifo_thresh;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             wen;
    logic [WIDTH-1:0] wdata;
    logic             ren;
    logic [WIDTH-1:0] rdata;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [2:0]       used_slots;
    logic [2:0]       free_slots;
    logic             overflow;
    logic             underflow;
    logic [2:0]       high_water;

    int total_cnt = 0;
    int pass_cnt  = 0;

    nx_fifo_thresh #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(4), .AE_LEVEL(1), .DATA_RESET(1)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata),
        .ren(ren), .rdata(rdata), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .used_slots(used_slots), .free_slots(free_slots),
        .overflow(overflow), .underflow(underflow), .high_water(high_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wen;
        logic [7:0] wd;
        logic       ren;
        logic       clr;
        int         used;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic [7:0] rd;
        int         hwm;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] q[$];

    function automatic vec_t mk(input logic w, input logic [7:0] d, input logic r,
                                input logic c, input int u, input logic f,
                                input logic e, input logic af, input logic ae,
                                input logic ov, input logic un, input logic [7:0] rd,
                                input int h);
        vec_t v;
        v.wen = w; v.wd = d; v.ren = r; v.clr = c; v.used = u; v.full = f;
        v.empty = e; v.af = af; v.ae = ae; v.ovf = ov; v.unf = un; v.rd = rd;
        v.hwm = h;
        return v;
    endfunction

    function automatic int exp_hwm(input int h);
`ifdef NX_FIFO_THRESH_HWM_EN
        return h;
`else
        return 0 * h;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_used"},  used_slots,   0);
        check({tag, "_free"},  free_slots,   DEPTH);
        check({tag, "_empty"}, empty,        1);
        check({tag, "_full"},  full,         0);
        check({tag, "_ae"},    almost_empty, 1);
        check({tag, "_af"},    almost_full,  0);
        check({tag, "_rdata"}, rdata,        0);
        check({tag, "_ovf"},   overflow,     0);
        check({tag, "_unf"},   underflow,    0);
        check({tag, "_hwm"},   high_water,   0);
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        wen = w; wdata = d; ren = r; clear = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int peak;
        rst = 1'b1; clear = 1'b0; wen = 1'b0; wdata = '0; ren = 1'b0;

        //        wen wd     ren clr used full emp af ae ovf unf rdata  hwm
        vecs.push_back(mk(1, 8'h11, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'h11, 0));
        vecs.push_back(mk(1, 8'h12, 0, 0, 2, 0, 0, 0, 0, 0, 0, 8'h11, 1));
        vecs.push_back(mk(1, 8'h13, 0, 0, 3, 0, 0, 0, 0, 0, 0, 8'h11, 2));
        vecs.push_back(mk(1, 8'h14, 0, 0, 4, 0, 0, 1, 0, 0, 0, 8'h11, 3));
        vecs.push_back(mk(1, 8'h15, 0, 0, 5, 1, 0, 1, 0, 0, 0, 8'h11, 4));
        vecs.push_back(mk(1, 8'hAA, 1, 0, 4, 0, 0, 1, 0, 1, 0, 8'h12, 5));
        vecs.push_back(mk(0, 8'h00, 0, 0, 4, 0, 0, 1, 0, 0, 0, 8'h12, 5));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3, 0, 0, 0, 0, 0, 0, 8'h13, 5));
        vecs.push_back(mk(1, 8'h77, 1, 1, 0, 0, 1, 0, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h5A, 1, 0, 1, 0, 0, 0, 1, 0, 1, 8'h5A, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'h5A, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 1, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 1));

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        check_idle_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven directed sequence
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wen, vecs[i].wd, vecs[i].ren, vecs[i].clr);
            check($sformatf("v%0d_used", i),  used_slots,   vecs[i].used);
            check($sformatf("v%0d_free", i),  free_slots,   DEPTH - vecs[i].used);
            check($sformatf("v%0d_full", i),  full,         vecs[i].full);
            check($sformatf("v%0d_empty", i), empty,        vecs[i].empty);
            check($sformatf("v%0d_af", i),    almost_full,  vecs[i].af);
            check($sformatf("v%0d_ae", i),    almost_empty, vecs[i].ae);
            check($sformatf("v%0d_ovf", i),   overflow,     vecs[i].ovf);
            check($sformatf("v%0d_unf", i),   underflow,    vecs[i].unf);
            check($sformatf("v%0d_rdata", i), rdata,        vecs[i].rd);
            check($sformatf("v%0d_hwm", i),   high_water,   exp_hwm(vecs[i].hwm));
        end

        // Interleaved 7 writes / 7 reads with scoreboard; pointers wrap past 4
        peak = 1;
        for (int c = 0; c < 10; c++) begin
            logic m_full;
            logic m_empty;
            @(negedge clk);
            wen = (c < 7); wdata = 8'($urandom_range(1, 255)); ren = (c >= 3); clear = 1'b0;
            m_full  = (q.size() == DEPTH);
            m_empty = (q.size() == 0);
            if (ren && !m_empty) begin
                check($sformatf("sb%0d_rdata", c), rdata, q[0]);
                void'(q.pop_front());
            end
            if (wen && !m_full) begin
                q.push_back(wdata);
            end
            @(posedge clk);
            #1;
            check($sformatf("sb%0d_used", c), used_slots, q.size());
            if (q.size() > peak) peak = q.size();
        end
        drive(0, 8'h00, 0, 0);
        check("sb_empty_end", empty, 1);
        check("sb_hwm", high_water, exp_hwm(peak));

        // Asynchronous reset mid-cycle with three entries held
        drive(1, 8'h21, 0, 0);
        drive(1, 8'h22, 0, 0);
        drive(1, 8'h23, 1, 0);
        drive(1, 8'h24, 0, 0);
        check("pre_rst_used", used_slots, 3);
        check("pre_rst_rdata", rdata, 8'h22);
        #2;
        rst = 1'b1;
        #1;
        check_idle_state("midrst");
        @(negedge clk);
        rst = 1'b0; wen = 1'b0; ren = 1'b0;

        // Recovery: first write after reset appears one cycle later
        drive(1, 8'h3C, 0, 0);
        check("post_rst_used", used_slots, 1);
        check("post_rst_rdata", rdata, 8'h3C);
        drive(0, 8'h00, 0, 0);
        check("post_rst_hwm", high_water, exp_hwm(1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
